// File: rtl/ftb_update_encoder.sv
// FTB update encoder: compresses resolved branch info into FTB entry format.
// Optional FTB_UPD_STAT_EN enables the drop/accept statistics counters.
`ifndef FTB_FALLTHRU_WIDTH
`define FTB_FALLTHRU_WIDTH 4
`endif
`ifndef FTB_TARGET_WIDTH
`define FTB_TARGET_WIDTH 12
`endif

package ftb_pkg;
    localparam int XLEN = 64;
    localparam int FW   = `FTB_FALLTHRU_WIDTH;
    localparam int TW   = `FTB_TARGET_WIDTH;

    typedef enum logic [2:0] {
        BR_COND = 3'd0,
        BR_JAL  = 3'd1,
        BR_JALR = 3'd2,
        BR_CALL = 3'd3,
        BR_RET  = 3'd4
    } BranchType;

    typedef enum logic [1:0] {
        TAR_FIT = 2'd0,
        TAR_OVF = 2'd1,
        TAR_UDF = 2'd2
    } tarStat_e;

    typedef struct packed {
        logic            carry;
        logic [FW-1:0]   fallthruAddr;
        tarStat_e        tarStat;
        logic [TW-1:0]   targetAddr;
        BranchType       branch_type;
        logic [1:0]      counter;
    } ftbInfo_t;

    typedef struct packed {
        logic [XLEN-1:0] startAddr;
        ftbInfo_t        info;
    } BPupdateInfo_t;
endpackage

module ftb_update_encoder
    import ftb_pkg::*;
#(
    parameter int XLEN       = ftb_pkg::XLEN,
    parameter int FALLTHRU_W = `FTB_FALLTHRU_WIDTH,
    parameter int TARGET_W   = `FTB_TARGET_WIDTH,
    parameter int DEPTH      = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            i_vld,
    output logic            i_rdy,
    input  logic [XLEN-1:0] i_startAddr,
    input  logic [XLEN-1:0] i_fallthruAddr,
    input  logic [XLEN-1:0] i_targetAddr,
    input  BranchType       i_branch_type,
    input  logic            i_taken,
    input  logic            i_hit,
    input  logic [1:0]      i_old_counter,
    output logic            o_vld,
    input  logic            o_rdy,
    output BPupdateInfo_t   o_update,
    output logic            o_drop,
    output logic [15:0]     o_drop_cnt
);

    localparam int HFW = XLEN - FALLTHRU_W - 1;
    localparam int HTW = XLEN - TARGET_W - 1;
    localparam int PW  = $clog2(DEPTH);

    logic [HFW-1:0] s_hf, s_hf_p1, f_hf;
    logic [HTW-1:0] s_ht, s_ht_p1, s_ht_m1, t_ht;
    logic           f_ok, t_ok, enc_ok;
    BPupdateInfo_t  enc;

    assign s_hf    = i_startAddr[XLEN-1:FALLTHRU_W+1];
    assign f_hf    = i_fallthruAddr[XLEN-1:FALLTHRU_W+1];
    assign s_ht    = i_startAddr[XLEN-1:TARGET_W+1];
    assign t_ht    = i_targetAddr[XLEN-1:TARGET_W+1];
    assign s_hf_p1 = s_hf + HFW'(1);
    assign s_ht_p1 = s_ht + HTW'(1);
    assign s_ht_m1 = s_ht - HTW'(1);

    always_comb begin
        enc                   = '0;
        f_ok                  = 1'b1;
        t_ok                  = 1'b1;
        enc.startAddr         = i_startAddr;
        enc.info.fallthruAddr = i_fallthruAddr[FALLTHRU_W:1];
        enc.info.targetAddr   = i_targetAddr[TARGET_W:1];
        enc.info.branch_type  = i_branch_type;
        unique case (1'b1)
            (f_hf == s_hf):    enc.info.carry = 1'b0;
            (f_hf == s_hf_p1): enc.info.carry = 1'b1;
            default:           f_ok = 1'b0;
        endcase
        // hi() compares wrap modulo the region count, so top/bottom wrap
        // lands naturally in OVF/UDF.
        unique case (1'b1)
            (t_ht == s_ht):    enc.info.tarStat = TAR_FIT;
            (t_ht == s_ht_p1): enc.info.tarStat = TAR_OVF;
            (t_ht == s_ht_m1): enc.info.tarStat = TAR_UDF;
            default:           t_ok = 1'b0;
        endcase
        if (i_hit) begin
            if (i_taken)
                enc.info.counter = (i_old_counter == 2'd3) ? 2'd3
                                 : i_old_counter + 2'd1;
            else
                enc.info.counter = (i_old_counter == 2'd0) ? 2'd0
                                 : i_old_counter - 2'd1;
        end else begin
            enc.info.counter = i_taken ? 2'b10 : 2'b01;
        end
    end

    assign enc_ok = f_ok && t_ok;

    logic          acc, push, pop, drop_ev;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          drop_q;
    BPupdateInfo_t mem_q [DEPTH];

    assign i_rdy   = (cnt_q < (PW+1)'(DEPTH));
    assign o_vld   = (cnt_q != '0);
    assign acc     = i_vld && i_rdy;
    assign push    = acc && enc_ok && !flush;
    assign drop_ev = acc && !enc_ok && !flush;
    assign pop     = o_vld && o_rdy;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) wptr_d = wptr_q + PW'(1);
            if (pop)  rptr_d = rptr_q + PW'(1);
            if (push && !pop) cnt_d = cnt_q + (PW+1)'(1);
            if (pop && !push) cnt_d = cnt_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            drop_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            drop_q <= drop_ev;
            if (push) mem_q[wptr_q] <= enc;
        end
    end

    assign o_update = o_vld ? mem_q[rptr_q] : '0;
    assign o_drop   = drop_q;

`ifdef FTB_UPD_STAT_EN
    logic [15:0] drop_cnt_q, acc_cnt_q;
    logic        unused_stat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
            acc_cnt_q  <= '0;
        end else begin
            if (drop_ev && drop_cnt_q != 16'hFFFF)
                drop_cnt_q <= drop_cnt_q + 16'd1;
            if (push && acc_cnt_q != 16'hFFFF)
                acc_cnt_q <= acc_cnt_q + 16'd1;
        end
    end

    assign o_drop_cnt  = drop_cnt_q;
    assign unused_stat = ^acc_cnt_q;
`else
    assign o_drop_cnt = '0;
`endif

    logic unused_bits;
    assign unused_bits = i_fallthruAddr[0] ^ i_targetAddr[0];

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && i_vld)
            assert (!i_startAddr[0] && !i_fallthruAddr[0] && !i_targetAddr[0]);
    end
`endif

endmodule
